// File: rtl/ser_frame_tx.sv
// Parallel-to-serial frame transmitter: buffers WIDTH-bit words in a small FIFO
// and shifts each one out a bit per clock, with an optional idle gap between frames.
module ser_frame_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic [3:0]               bit_idx,
    output logic                     frame_end,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam bit          MSB     = (MSB_FIRST != 0);
    localparam bit          HAS_GAP = (GAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [3:0]       gap_cnt;
    logic             push;
    logic             pop;

    // No write bypass: readiness depends only on the stored count.
    assign din_ready = ~reset & (fifo_count != CW'(DEPTH));
    assign push      = din_valid & din_ready;
    assign head      = mem[rd_ptr];
    assign shifted   = MSB ? (sreg << 1) : (sreg >> 1);

    // Pop whenever the engine is about to start a new frame and a word is waiting.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = (fifo_count != '0);
            ST_SHIFT: pop = frame_end && !HAS_GAP && (fifo_count != '0);
            ST_GAP:   pop = (gap_cnt == 4'd1) && (fifo_count != '0);
            default:  pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Frame engine; outputs default to idle values and are overridden per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            gap_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            bit_idx   <= '0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            bit_idx   <= '0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            if (pop) begin
                state     <= ST_SHIFT;
                sreg      <= head;
                ser_out   <= MSB ? head[WIDTH-1] : head[0];
                ser_valid <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_SHIFT: begin
                        if (!frame_end) begin
                            sreg      <= shifted;
                            ser_out   <= MSB ? shifted[WIDTH-1] : shifted[0];
                            ser_valid <= 1'b1;
                            bit_idx   <= bit_idx + 4'd1;
                            frame_end <= (bit_idx == 4'(WIDTH-2));
                            busy      <= 1'b1;
                        end else if (HAS_GAP) begin
                            state   <= ST_GAP;
                            gap_cnt <= 4'(GAP);
                            busy    <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt != 4'd1) begin
                            gap_cnt <= gap_cnt - 4'd1;
                            busy    <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: three instances (defaults, GAP=2, LSB-first) checked
// against expected bit streams computed directly from the transmitted words.
module tb_ser_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       dv_a, dv_g, dv_l;

    logic       a_rdy, a_so, a_sv, a_fe, a_busy;
    logic [3:0] a_idx;
    logic [2:0] a_cnt;
    logic       g_rdy, g_so, g_sv, g_fe, g_busy;
    logic [3:0] g_idx;
    logic [2:0] g_cnt;
    logic       l_rdy, l_so, l_sv, l_fe, l_busy;
    logic [3:0] l_idx;
    logic [2:0] l_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ser_frame_tx u_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(dv_a), .din_ready(a_rdy),
        .ser_out(a_so), .ser_valid(a_sv), .bit_idx(a_idx), .frame_end(a_fe),
        .busy(a_busy), .fifo_count(a_cnt)
    );

    ser_frame_tx #(.GAP(2)) u_g (
        .clk(clk), .reset(reset), .din(din), .din_valid(dv_g), .din_ready(g_rdy),
        .ser_out(g_so), .ser_valid(g_sv), .bit_idx(g_idx), .frame_end(g_fe),
        .busy(g_busy), .fifo_count(g_cnt)
    );

    ser_frame_tx #(.MSB_FIRST(0)) u_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(dv_l), .din_ready(l_rdy),
        .ser_out(l_so), .ser_valid(l_sv), .bit_idx(l_idx), .frame_end(l_fe),
        .busy(l_busy), .fifo_count(l_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din   = '0;
        dv_a  = 1'b0;
        dv_g  = 1'b0;
        dv_l  = 1'b0;
        repeat (2) step();
        checks++;
        if ({a_sv, a_so, a_idx, a_fe, a_busy, a_cnt} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0", {a_sv, a_so, a_idx, a_fe, a_busy, a_cnt});
        end
        checks++;
        if ({a_rdy, g_rdy, l_rdy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 000", {a_rdy, g_rdy, l_rdy});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_rdy, g_rdy, l_rdy} !== 3'b111) begin
            failures++;
            $display("FAIL ready_after_reset: got %b expected 111", {a_rdy, g_rdy, l_rdy});
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        for (int n = 0; n < 4; n++) begin
            w    = (n == 0) ? 8'hA5 : 8'($urandom);
            din  = w;
            dv_a = 1'b1;
            step();
            dv_a = 1'b0;
            for (int k = 0; k < 8; k++) begin
                step();
                checks++;
                if ({a_sv, a_so, a_idx, a_fe} !== {1'b1, w[7-k], 4'(k), (k == 7)}) begin
                    failures++;
                    $display("FAIL single w=%h k=%0d: got sv/so/idx/fe=%b expected %b",
                             w, k, {a_sv, a_so, a_idx, a_fe}, {1'b1, w[7-k], 4'(k), (k == 7)});
                end
            end
            step();
            checks++;
            if ({a_busy, a_sv} !== 2'b00) begin
                failures++;
                $display("FAIL single_idle w=%h: got busy/sv=%b expected 00", w, {a_busy, a_sv});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w0, w1;
        logic [15:0] s;
        for (int n = 0; n < 3; n++) begin
            w0   = (n == 0) ? 8'h3C : 8'($urandom);
            w1   = (n == 0) ? 8'hFF : 8'($urandom);
            s    = {w0, w1};
            din  = w0;
            dv_a = 1'b1;
            step();
            din = w1;
            step();
            dv_a = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (k > 0) step();
                checks++;
                if ({a_sv, a_so, a_idx, a_fe} !== {1'b1, s[15-k], 4'(k % 8), (k % 8 == 7)}) begin
                    failures++;
                    $display("FAIL b2b %h/%h k=%0d: got sv/so/idx/fe=%b expected %b", w0, w1, k,
                             {a_sv, a_so, a_idx, a_fe}, {1'b1, s[15-k], 4'(k % 8), (k % 8 == 7)});
                end
            end
            step();
            checks++;
            if ({a_busy, a_sv} !== 2'b00) begin
                failures++;
                $display("FAIL b2b_idle: got busy/sv=%b expected 00", {a_busy, a_sv});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [6];
        logic [7:0] exp_q [$];
        logic [7:0] acc;
        logic [7:0] exp_w;
        logic       accept;
        int sent = 0, got = 0, cyc = 0, nb = 0, maxcnt = 0, idx_bad = 0, rdy_bad = 0;
        bit saw_full = 1'b0;
        acc = '0;
        for (int i = 0; i < 6; i++) words[i] = 8'(i * 40 + $urandom_range(0, 39));
        din  = words[0];
        dv_a = 1'b1;
        while (got < 6 && cyc < 300) begin
            accept = dv_a & a_rdy;
            if (accept) exp_q.push_back(din);
            step();
            cyc++;
            if (accept) begin
                sent++;
                if (sent < 6) din = words[sent];
                else dv_a = 1'b0;
            end
            if (int'(a_cnt) > maxcnt) maxcnt = int'(a_cnt);
            if (a_cnt == 3'd4) saw_full = 1'b1;
            if ((a_cnt == 3'd4) == a_rdy) rdy_bad++;
            if (a_sv) begin
                if (a_idx !== 4'(nb)) idx_bad++;
                acc = {acc[6:0], a_so};
                nb++;
                if (a_fe) begin
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++;
                    if (acc !== exp_w) begin
                        failures++;
                        $display("FAIL bp_frame %0d: got %h expected %h", got, acc, exp_w);
                    end
                    got++;
                    nb = 0;
                end
            end
        end
        dv_a = 1'b0;
        checks++;
        if (got != 6 || sent != 6) begin
            failures++;
            $display("FAIL bp_complete: got frames=%0d sent=%0d expected 6/6", got, sent);
        end
        checks++;
        if (maxcnt > 4 || !saw_full) begin
            failures++;
            $display("FAIL bp_fill: got max_count=%0d saw_full=%0d expected 4/1", maxcnt, saw_full);
        end
        checks++;
        if (rdy_bad != 0) begin
            failures++;
            $display("FAIL bp_ready: got %0d cycles with wrong din_ready expected 0", rdy_bad);
        end
        checks++;
        if (idx_bad != 0) begin
            failures++;
            $display("FAIL bp_bit_idx: got %0d bad bit_idx cycles expected 0", idx_bad);
        end
        step();
    endtask

    task automatic test_gap();
        logic [7:0] w0, w1, w;
        logic [7:0] exp_v, got_v;
        int pos;
        for (int n = 0; n < 2; n++) begin
            w0   = (n == 0) ? 8'h81 : 8'($urandom);
            w1   = (n == 0) ? 8'h01 : 8'($urandom);
            din  = w0;
            dv_g = 1'b1;
            step();
            din = w1;
            step();
            dv_g = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (c > 0) step();
                pos = c % 10;
                w   = (c < 10) ? w0 : w1;
                if (pos < 8) exp_v = {1'b1, w[7-pos], 4'(pos), (pos == 7), 1'b1};
                else         exp_v = {1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
                got_v = {g_sv, g_so, g_idx, g_fe, g_busy};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL gap %h/%h c=%0d: got sv/so/idx/fe/busy=%b expected %b",
                             w0, w1, c, got_v, exp_v);
                end
            end
            step();
            checks++;
            if ({g_busy, g_sv} !== 2'b00) begin
                failures++;
                $display("FAIL gap_idle: got busy/sv=%b expected 00", {g_busy, g_sv});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        int bad = 0;
        din  = 8'hF0;
        dv_a = 1'b1;
        step();
        din = 8'($urandom);
        step();
        din = 8'($urandom);
        step();
        dv_a = 1'b0;
        repeat (2) step();
        checks++;
        if ({a_idx, a_sv, a_cnt} !== {4'd3, 1'b1, 3'd2}) begin
            failures++;
            $display("FAIL mid_setup: got idx/sv/cnt=%b expected %b", {a_idx, a_sv, a_cnt}, {4'd3, 1'b1, 3'd2});
        end
        reset = 1'b1;
        din   = 8'hAA;
        dv_a  = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready: got %b expected 0", a_rdy);
        end
        step();
        reset = 1'b0;
        dv_a  = 1'b0;
        checks++;
        if ({a_sv, a_idx, a_cnt, a_fe, a_busy} !== 10'd0) begin
            failures++;
            $display("FAIL mid_after_reset: got %b expected 0", {a_sv, a_idx, a_cnt, a_fe, a_busy});
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_fe || a_sv || a_cnt != 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_quiet: got %0d active cycles expected 0", bad);
        end
        w    = 8'h55;
        din  = w;
        dv_a = 1'b1;
        step();
        dv_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({a_sv, a_so, a_idx, a_fe} !== {1'b1, w[7-k], 4'(k), (k == 7)}) begin
                failures++;
                $display("FAIL mid_fresh k=%0d: got %b expected %b", k,
                         {a_sv, a_so, a_idx, a_fe}, {1'b1, w[7-k], 4'(k), (k == 7)});
            end
        end
        step();
    endtask

    task automatic test_lsb();
        logic [7:0] w;
        for (int n = 0; n < 4; n++) begin
            w    = (n == 0) ? 8'h01 : 8'($urandom);
            din  = w;
            dv_l = 1'b1;
            step();
            dv_l = 1'b0;
            for (int k = 0; k < 8; k++) begin
                step();
                checks++;
                if ({l_sv, l_so, l_idx, l_fe} !== {1'b1, w[k], 4'(k), (k == 7)}) begin
                    failures++;
                    $display("FAIL lsb w=%h k=%0d: got %b expected %b", w, k,
                             {l_sv, l_so, l_idx, l_fe}, {1'b1, w[k], 4'(k), (k == 7)});
                end
            end
            step();
            checks++;
            if ({l_busy, l_sv} !== 2'b00) begin
                failures++;
                $display("FAIL lsb_idle: got busy/sv=%b expected 00", {l_busy, l_sv});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_lsb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
